// File: rtl/som_pkg.sv
// Shared constants and FSM encoding for the SOM controller RAM responder.
package som_pkg;

  localparam int SOM_AW    = 18;
  localparam int SOM_DW    = 8;
  localparam int SOM_DEPTH = 40960;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DUMP = 2'd2
  } som_state_e;

endpackage

// File: rtl/som_sram_array.sv
// Behavioural single-port word array with registered reads; controller port has priority over host port.
// With RAM_PARITY_EN defined each word carries an even-parity bit checked on every read (sticky par_err).
module som_sram_array
  import som_pkg::*;
#(
  parameter int DW    = SOM_DW,
  parameter int DEPTH = SOM_DEPTH,
  parameter int AW    = SOM_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ctl_we,
  input  logic          ctl_re,
  input  logic          ctl_oor,
  input  logic [AW-1:0] ctl_addr,
  input  logic [DW-1:0] ctl_wdata,
  input  logic          host_we,
  input  logic          host_re,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic [DW-1:0] ctl_rdata,
`ifdef RAM_PARITY_EN
  output logic          par_err,
`endif
  output logic [DW-1:0] host_rdata
);

  localparam int IW = $clog2(DEPTH);
`ifdef RAM_PARITY_EN
  localparam int SW = DW + 1;
`else
  localparam int SW = DW;
`endif

  logic [SW-1:0] mem [DEPTH];

  logic          ctl_sel;
  logic [AW-1:0] acc_addr;
  logic [IW-1:0] acc_idx;
  logic          acc_we;
  logic [DW-1:0] acc_wdata;
  logic          host_rd;
  logic [SW-1:0] wr_word;
  logic [SW-1:0] rd_word;
  logic          addr_hi_unused;

  // One access per cycle: the controller owns the port whenever it asks for it.
  assign ctl_sel   = ctl_we | ctl_re;
  assign acc_addr  = ctl_sel ? ctl_addr  : host_addr;
  assign acc_we    = ctl_sel ? ctl_we    : host_we;
  assign acc_wdata = ctl_sel ? ctl_wdata : host_wdata;
  assign host_rd   = host_re & ~ctl_sel;
  assign acc_idx   = acc_addr[IW-1:0];
  assign addr_hi_unused = ^acc_addr[AW-1:IW];
  assign rd_word   = mem[acc_idx];

`ifdef RAM_PARITY_EN
  assign wr_word = {^acc_wdata, acc_wdata};
`else
  assign wr_word = acc_wdata;
`endif

  always_ff @(posedge clk) begin
    if (acc_we) begin
      mem[acc_idx] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_rdata  <= '0;
      host_rdata <= '0;
    end else begin
      if (ctl_re) begin
        ctl_rdata <= ctl_oor ? '0 : rd_word[DW-1:0];
      end
      if (host_rd) begin
        host_rdata <= rd_word[DW-1:0];
      end
    end
  end

`ifdef RAM_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err <= 1'b0;
    end else if (((ctl_re & ~ctl_oor) | host_rd) && (^rd_word)) begin
      par_err <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/som_ram_responder.sv
// Responder end of the SOM controller RAM interface plus a host LOAD/DUMP streaming port.
// Optional feature: RAM_PARITY_EN adds per-word even parity and the sticky par_err output.
module som_ram_responder
  import som_pkg::*;
#(
  parameter int DW    = SOM_DW,
  parameter int DEPTH = SOM_DEPTH,
  parameter int AW    = SOM_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] A,
  input  logic          OE,
  input  logic          WE,
  input  logic [DW-1:0] D,
  output logic [DW-1:0] Q,
  output logic          Q_valid,
  input  logic          load_start,
  input  logic          dump_start,
  input  logic          host_wvalid,
  output logic          host_wready,
  input  logic [DW-1:0] host_wdata,
  output logic          host_rvalid,
  input  logic          host_rready,
  output logic [DW-1:0] host_rdata,
  output logic          busy,
  output logic          load_done,
  output logic          dump_done,
  output logic          addr_err,
`ifdef RAM_PARITY_EN
  output logic          par_err,
`endif
  output logic [1:0]    state_dbg
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] END_CNT   = AW'(DEPTH);

  som_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          rvalid_q, rvalid_d;

  logic          ctl_act;
  logic          a_oor;
  logic          ctl_we;
  logic          ctl_re;
  logic          host_we;
  logic          host_re;
  logic          rd_accept;
  logic          load_last;
  logic          dump_last;

  assign ctl_act = OE | WE;
  assign a_oor   = (A >= END_CNT);
  assign ctl_we  = WE & ~a_oor;
  assign ctl_re  = OE & ~WE;

  // Host handshakes: a word moves on a rising edge where valid && ready are both high.
  // Producers hold valid and data until that edge; ready may depend combinationally on OE/WE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rvalid_d    = rvalid_q;
    host_wready = 1'b0;
    host_we     = 1'b0;
    host_re     = 1'b0;
    rd_accept   = 1'b0;
    load_last   = 1'b0;
    dump_last   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (load_start) begin
          state_d = ST_LOAD;
        end else if (dump_start) begin
          state_d = ST_DUMP;
        end
      end
      ST_LOAD: begin
        host_wready = ~ctl_act;
        if (host_wvalid && host_wready) begin
          host_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_ADDR) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            load_last = 1'b1;
          end
        end
      end
      ST_DUMP: begin
        // One outstanding word: the next read waits until the output register drains.
        host_re   = ~ctl_act & ~rvalid_q & (cnt_q < END_CNT);
        rd_accept = rvalid_q & host_rready;
        if (host_re) begin
          cnt_d    = cnt_q + 1'b1;
          rvalid_d = 1'b1;
        end else if (rd_accept) begin
          rvalid_d = 1'b0;
          if (cnt_q == END_CNT) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            dump_last = 1'b1;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        rvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rvalid_q  <= 1'b0;
      Q_valid   <= 1'b0;
      load_done <= 1'b0;
      dump_done <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rvalid_q  <= rvalid_d;
      Q_valid   <= ctl_re;
      load_done <= load_last;
      dump_done <= dump_last;
      if (ctl_act && a_oor) begin
        addr_err <= 1'b1;
      end
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign host_rvalid = rvalid_q;
  assign state_dbg   = state_q;

  som_sram_array #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk        (clk),
    .rst_n      (rst),
    .ctl_we     (ctl_we),
    .ctl_re     (ctl_re),
    .ctl_oor    (a_oor),
    .ctl_addr   (A),
    .ctl_wdata  (D),
    .host_we    (host_we),
    .host_re    (host_re),
    .host_addr  (cnt_q),
    .host_wdata (host_wdata),
    .ctl_rdata  (Q),
`ifdef RAM_PARITY_EN
    .par_err    (par_err),
`endif
    .host_rdata (host_rdata)
  );

endmodule

// File: tb/tb_som_ram_responder.sv
// Directed bench for som_ram_responder (DEPTH=16): reset, LOAD, LOAD under controller traffic, DUMP, edge cases.
module tb_som_ram_responder;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 18;

  logic          clk;
  logic          rst;
  logic [AW-1:0] A;
  logic          OE;
  logic          WE;
  logic [DW-1:0] D;
  logic [DW-1:0] Q;
  logic          Q_valid;
  logic          load_start;
  logic          dump_start;
  logic          host_wvalid;
  logic          host_wready;
  logic [DW-1:0] host_wdata;
  logic          host_rvalid;
  logic          host_rready;
  logic [DW-1:0] host_rdata;
  logic          busy;
  logic          load_done;
  logic          dump_done;
  logic          addr_err;
  logic [1:0]    state_dbg;
`ifdef RAM_PARITY_EN
  logic          par_err;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q[$];

  som_ram_responder #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .A           (A),
    .OE          (OE),
    .WE          (WE),
    .D           (D),
    .Q           (Q),
    .Q_valid     (Q_valid),
    .load_start  (load_start),
    .dump_start  (dump_start),
    .host_wvalid (host_wvalid),
    .host_wready (host_wready),
    .host_wdata  (host_wdata),
    .host_rvalid (host_rvalid),
    .host_rready (host_rready),
    .host_rdata  (host_rdata),
    .busy        (busy),
    .load_done   (load_done),
    .dump_done   (dump_done),
    .addr_err    (addr_err),
`ifdef RAM_PARITY_EN
    .par_err     (par_err),
`endif
    .state_dbg   (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    OE = 1'b1; WE = 1'b0; A = addr;
    next_cycle();
    OE = 1'b0;
    #1;
    check("rd_q", Q, exp);
    check("rd_qvalid", Q_valid, 1'b1);
    next_cycle();
    #1;
    check("rd_qvalid_drop", Q_valid, 1'b0);
    check("rd_q_hold", Q, exp);
  endtask

  // LOAD of words addr+1; OE held on loop cycles oe_lo..oe_hi reading oe_addr.
  task automatic do_load(input int oe_lo, input int oe_hi, input logic [AW-1:0] oe_addr,
                         input logic [DW-1:0] oe_exp);
    int idx = 0;
    int cyc = 0;
    bit cur_oe;
    bit prev_oe = 1'b0;
    bit acc;
    load_start = 1'b1;
    next_cycle();
    load_start = 1'b0;
    while (idx < DEPTH && cyc < 200) begin
      cur_oe      = (cyc >= oe_lo) && (cyc <= oe_hi);
      OE          = cur_oe;
      A           = oe_addr;
      host_wvalid = 1'b1;
      host_wdata  = DW'(idx + 1);
      #1;
      check("load_wready", host_wready, !cur_oe);
      check("load_done_early", load_done, 1'b0);
      if (prev_oe) begin
        check("load_qvalid", Q_valid, 1'b1);
        check("load_q", Q, oe_exp);
      end
      acc     = host_wready;
      prev_oe = cur_oe;
      next_cycle();
      if (acc) idx++;
      cyc++;
    end
    host_wvalid = 1'b0;
    OE          = 1'b0;
    check("load_count", idx, DEPTH);
    check("load_done", load_done, 1'b1);
    check("load_busy_end", busy, 1'b0);
    next_cycle();
    check("load_done_pulse", load_done, 1'b0);
  endtask

  initial begin
    int cyc;
    int done_seen;
    bit held;
    logic [DW-1:0] held_data;
    logic [DW-1:0] exp_w;

    rst = 1'b0; A = '0; OE = 1'b0; WE = 1'b0; D = '0;
    load_start = 1'b0; dump_start = 1'b0;
    host_wvalid = 1'b0; host_wdata = '0; host_rready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_q", Q, 0);
    check("rst_qvalid", Q_valid, 0);
    check("rst_wready", host_wready, 0);
    check("rst_rvalid", host_rvalid, 0);
    check("rst_rdata", host_rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_load_done", load_done, 0);
    check("rst_dump_done", dump_done, 0);
    check("rst_addr_err", addr_err, 0);
    rst = 1'b1;
    next_cycle();

    // Reset in the middle of a LOAD after 10 words
    load_start = 1'b1;
    next_cycle();
    load_start = 1'b0;
    check("t1_busy", busy, 1);
    check("t1_state", state_dbg, 2'd1);
    for (int i = 0; i < 10; i++) begin
      host_wvalid = 1'b1;
      host_wdata  = DW'(8'h50 + i);
      next_cycle();
    end
    host_wvalid = 1'b0;
    rst = 1'b0;
    #1;
    check("t1_busy_rst", busy, 0);
    check("t1_state_rst", state_dbg, 2'd0);
    check("t1_wready_rst", host_wready, 0);
    check("t1_load_done_rst", load_done, 0);
    next_cycle();
    rst = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      if (load_done) done_seen++;
    end
    check("t1_no_load_done", done_seen, 0);
    ctl_read(9, 8'h59);

    // Full LOAD, then controller read
    do_load(-1, -2, '0, '0);
    ctl_read(5, 8'h06);
    ctl_read(15, 8'h10);

    // Wipe memory through the controller so LOAD below is observable
    for (int i = 0; i < DEPTH; i++) begin
      WE = 1'b1; A = AW'(i); D = '0;
      next_cycle();
    end
    WE = 1'b0;
    ctl_read(0, 8'h00);

    // LOAD with OE high on cycles 3..6
    do_load(3, 6, '0, 8'h01);

    // DUMP with a stalling reader
    dump_start = 1'b1;
    next_cycle();
    dump_start = 1'b0;
    check("t4_busy", busy, 1);
    for (int i = 1; i <= DEPTH; i++) exp_q.push_back(DW'(i));
    cyc = 0; done_seen = 0; held = 1'b0; held_data = '0;
    while (exp_q.size() > 0 && cyc < 300) begin
      host_rready = (cyc % 3) != 2;
      #1;
      if (dump_done) done_seen++;
      if (held) begin
        check("t4_rvalid_held", host_rvalid, 1);
        check("t4_rdata_stable", host_rdata, held_data);
      end
      if (host_rvalid && host_rready) begin
        exp_w = exp_q.pop_front();
        check("t4_dump_word", host_rdata, exp_w);
      end
      held      = host_rvalid && !host_rready;
      held_data = host_rdata;
      next_cycle();
      cyc++;
    end
    host_rready = 1'b0;
    check("t4_dump_count", exp_q.size(), 0);
    check("t4_no_early_done", done_seen, 0);
    check("t4_dump_done", dump_done, 1);
    check("t4_busy_end", busy, 0);
    next_cycle();
    check("t4_dump_done_pulse", dump_done, 0);
    check("t4_rvalid_end", host_rvalid, 0);

    // WE wins over OE; out-of-range read
    WE = 1'b1; OE = 1'b1; A = 3; D = 8'hAA;
    next_cycle();
    WE = 1'b0; OE = 1'b0;
    #1;
    check("t5_we_oe_qvalid", Q_valid, 0);
    ctl_read(3, 8'hAA);
    check("t5_addr_err_pre", addr_err, 0);
    ctl_read(AW'(DEPTH), 8'h00);
    check("t5_addr_err", addr_err, 1);
    ctl_read(3, 8'hAA);
    check("t5_addr_err_sticky", addr_err, 1);

`ifdef RAM_PARITY_EN
    // Corrupt a stored bit and read it back
    check("t6_par_err_pre", par_err, 0);
    u_dut.u_array.mem[2] = u_dut.u_array.mem[2] ^ 9'h001;
    ctl_read(2, 8'h02);
    check("t6_par_err", par_err, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
